// File: rtl/frame_write_arbiter.sv
// Frame-buffer write-port owner: merges camera pixels (via a small jitter FIFO),
// draw requests and a whole-buffer clear sweep into one registered BRAM write per cycle.
module frame_write_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int NUM_PIXELS = 43200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              cam_valid_in,
    input  logic [ADDR_W-1:0] cam_addr_in,
    input  logic [3:0]        cam_gray_in,
    input  logic              draw_valid_in,
    output logic              draw_ready_out,
    input  logic [ADDR_W-1:0] draw_addr_in,
    input  logic [1:0]        draw_color_in,
    input  logic              clear_in,
    output logic              clear_busy_out,
    output logic              bram_we_out,
    output logic [ADDR_W-1:0] bram_addr_out,
    output logic [7:0]        bram_data_out,
    output logic              cam_drop_out
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = ADDR_W + 4;
    localparam logic [CNT_W-1:0]  URGENT_LVL = CNT_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W-1:0]  FULL_LVL   = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(NUM_PIXELS - 1);

    typedef enum logic {ARB, CLEAR} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   sweep_q, sweep_d;
    logic [ENTRY_W-1:0]  fifo_mem_q [FIFO_DEPTH];
    logic [ENTRY_W-1:0]  fifo_mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          data_q, data_d;
    logic                drop_q, drop_d;

    logic                urgent;
    logic                pop;
    logic                push;
    logic                push_ok;
    logic                flush;
    logic [ENTRY_W-1:0]  head;

    // Near-full FIFO pre-empts draw so the unstallable camera never overflows.
    assign urgent         = (count_q >= URGENT_LVL);
    assign head           = fifo_mem_q[rd_ptr_q];
    assign draw_ready_out = !rst_in && (state_q == ARB) && !urgent;
    assign clear_busy_out = (state_q == CLEAR);
    assign bram_we_out    = we_q;
    assign bram_addr_out  = addr_q;
    assign bram_data_out  = data_q;
    assign cam_drop_out   = drop_q;

    always_comb begin
        state_d    = state_q;
        sweep_d    = sweep_q;
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        we_d       = 1'b0;
        addr_d     = '0;
        data_d     = 8'h00;
        drop_d     = 1'b0;
        pop        = 1'b0;
        push       = 1'b0;
        push_ok    = 1'b0;
        flush      = 1'b0;

        case (state_q)
            ARB: begin
                if (urgent) begin
                    pop = 1'b1;
                end else if (draw_valid_in) begin
                    we_d   = 1'b1;
                    addr_d = draw_addr_in;
                    data_d = {2'b11, 4'b0000, draw_color_in};
                end else if (count_q != '0) begin
                    pop = 1'b1;
                end
                if (pop) begin
                    we_d   = 1'b1;
                    addr_d = head[ENTRY_W-1:4];
                    data_d = {2'b00, head[3:0], 2'b00};
                end
                // The write chosen this cycle still goes out; the sweep begins next cycle.
                if (clear_in) begin
                    state_d = CLEAR;
                    sweep_d = '0;
                    flush   = 1'b1;
                end else begin
                    push = cam_valid_in;
                end
            end
            CLEAR: begin
                we_d   = 1'b1;
                addr_d = sweep_q;
                data_d = 8'h00;
                if (sweep_q == LAST_ADDR) begin
                    state_d = ARB;
                    sweep_d = '0;
                end else begin
                    sweep_d = sweep_q + 1'b1;
                end
            end
            default: state_d = ARB;
        endcase

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            push_ok = push && ((count_q != FULL_LVL) || pop);
            drop_d  = push && !push_ok;
            if (push_ok) begin
                fifo_mem_d[wr_ptr_q] = {cam_addr_in, cam_gray_in};
                wr_ptr_d             = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            case ({push_ok, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q    <= ARB;
            sweep_q    <= '0;
            fifo_mem_q <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= 8'h00;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sweep_q    <= sweep_d;
            fifo_mem_q <= fifo_mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            drop_q     <= drop_d;
        end
    end

endmodule
